// File: rtl/md5_search_ctrl_pkg.sv
// Shared definitions for the hash-breaker search controller: FSM encoding,
// charset constants and bus widths.
package hb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] CHARSET_BASE = 8'h61;
  localparam int         CHARSET_SIZE = 26;
  localparam int         MSG_W        = 64;
  localparam int         HASH_W       = 128;
  // Bit length of an up-to-8-character candidate fits in 7 bits.
  localparam int         LEN_W        = 7;

  function automatic logic [7:0] digit_char(input logic [4:0] d);
    return CHARSET_BASE + {3'b000, d};
  endfunction

endpackage

// File: rtl/md5_search_ctrl_if.sv
// Host/core-facing signal bundle of md5_search_ctrl.
// start is a one-cycle request with no ready: the controller takes it only in
// IDLE or DONE and drops it otherwise; busy/done/found describe the outcome.
interface md5_search_ctrl_if import hb_pkg::*; ();

  logic              start;
  logic [HASH_W-1:0] target;
  logic [MSG_W-1:0]  core_message;
  logic [63:0]       core_length;
  logic [HASH_W-1:0] core_hash;
  logic              busy;
  logic              done;
  logic              found;
  logic [MSG_W-1:0]  result;
  logic [63:0]       result_len;
  logic [63:0]       tried;
  state_t            state;

  modport master (
    output start, target, core_hash,
    input  core_message, core_length, busy, done, found,
           result, result_len, tried, state
  );

  modport slave (
    input  start, target, core_hash,
    output core_message, core_length, busy, done, found,
           result, result_len, tried, state
  );

endinterface

// File: rtl/md5_search_ctrl_delay_line.sv
// Fixed-depth shift register with synchronous clear; tracks the candidates
// that are in flight inside the hash core.
module hb_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/md5_search_ctrl.sv
// Brute-force search controller: enumerates lowercase candidates into a
// pipelined md5 core and reports the first message whose hash hits the target.
module md5_search_ctrl import hb_pkg::*; #(
  parameter int PIPE_DEPTH = 64,
  parameter int MAX_CHARS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  md5_search_ctrl_if.slave  bus
);

  localparam int         CNT_W     = $clog2(PIPE_DEPTH + 1);
  localparam int         PW        = 1 + MSG_W + LEN_W;
  localparam logic [4:0] DIGIT_MAX = 5'(CHARSET_SIZE - 1);

  state_t            state_q, state_d;
  logic [4:0]        digit_q [MAX_CHARS];
  logic [4:0]        digit_d [MAX_CHARS];
  logic [4:0]        digit_nxt [MAX_CHARS];
  logic [3:0]        len_q, len_d, len_nxt;
  logic [HASH_W-1:0] target_q, target_d;
  logic [MSG_W-1:0]  msg_q, msg_d;
  logic [63:0]       clen_q, clen_d;
  logic [63:0]       tried_q, tried_d;
  logic [MSG_W-1:0]  result_q, result_d;
  logic [63:0]       rlen_q, rlen_d;
  logic              found_q, found_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;

  logic [MSG_W-1:0]  cand_msg;
  logic [LEN_W-1:0]  cand_len;
  logic              all_max, carry, last_cand;
  logic              issue, pipe_clr, match;
  logic [PW-1:0]     pipe_in, pipe_out;
  logic              pipe_v;
  logic [MSG_W-1:0]  pipe_msg;
  logic [LEN_W-1:0]  pipe_len;

  // Odometer: digit 0 is the last character; carry ripples within len_q.
  always_comb begin
    cand_msg = '0;
    all_max  = 1'b1;
    carry    = 1'b1;
    for (int i = 0; i < MAX_CHARS; i++) begin
      digit_nxt[i] = digit_q[i];
      if (i < int'(len_q)) begin
        cand_msg[8*i +: 8] = digit_char(digit_q[i]);
        if (digit_q[i] != DIGIT_MAX) all_max = 1'b0;
        if (carry) begin
          if (digit_q[i] == DIGIT_MAX) begin
            digit_nxt[i] = '0;
          end else begin
            digit_nxt[i] = digit_q[i] + 5'd1;
            carry        = 1'b0;
          end
        end
      end
    end
    len_nxt   = all_max ? len_q + 4'd1 : len_q;
    last_cand = all_max && (len_q == 4'(MAX_CHARS));
  end

  assign cand_len = {len_q, 3'b000};

  assign pipe_in  = {issue, cand_msg, cand_len};
  assign pipe_v   = pipe_out[PW-1];
  assign pipe_msg = pipe_out[PW-2 -: MSG_W];
  assign pipe_len = pipe_out[LEN_W-1:0];
  assign match    = pipe_v && (bus.core_hash == target_q) && !hit_q;

  hb_delay_line #(.W(PW), .DEPTH(PIPE_DEPTH)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .clr  (pipe_clr),
    .din  (pipe_in),
    .dout (pipe_out)
  );

  // A hit is registered first (hit_q) and reported in DONE one cycle later.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    target_d = target_q;
    msg_d    = msg_q;
    clen_d   = clen_q;
    tried_d  = tried_q;
    result_d = result_q;
    rlen_d   = rlen_q;
    found_d  = found_q;
    hit_d    = hit_q;
    issue    = 1'b0;
    pipe_clr = 1'b0;
    for (int i = 0; i < MAX_CHARS; i++) digit_d[i] = digit_q[i];

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d  = ST_RUN;
          target_d = bus.target;
          len_d    = 4'd1;
          tried_d  = '0;
          result_d = '0;
          rlen_d   = '0;
          found_d  = 1'b0;
          hit_d    = 1'b0;
          pipe_clr = 1'b1;
          for (int i = 0; i < MAX_CHARS; i++) digit_d[i] = '0;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (hit_q) begin
          state_d = ST_DONE;
          found_d = 1'b1;
          hit_d   = 1'b0;
        end else if (match) begin
          hit_d    = 1'b1;
          result_d = pipe_msg;
          rlen_d   = 64'(pipe_len);
        end else if (state_q == ST_RUN) begin
          issue   = 1'b1;
          msg_d   = cand_msg;
          clen_d  = 64'(cand_len);
          tried_d = tried_q + 64'd1;
          len_d   = len_nxt;
          for (int i = 0; i < MAX_CHARS; i++) digit_d[i] = digit_nxt[i];
          if (last_cand) state_d = ST_DRAIN;
        end else if (inflight_q == '0) begin
          state_d = ST_DONE;
          found_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pipe_clr) inflight_d = '0;
    else          inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(pipe_v);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= 4'd1;
      target_q   <= '0;
      msg_q      <= '0;
      clen_q     <= '0;
      tried_q    <= '0;
      result_q   <= '0;
      rlen_q     <= '0;
      found_q    <= 1'b0;
      hit_q      <= 1'b0;
      inflight_q <= '0;
      for (int i = 0; i < MAX_CHARS; i++) digit_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      target_q   <= target_d;
      msg_q      <= msg_d;
      clen_q     <= clen_d;
      tried_q    <= tried_d;
      result_q   <= result_d;
      rlen_q     <= rlen_d;
      found_q    <= found_d;
      hit_q      <= hit_d;
      inflight_q <= inflight_d;
      for (int i = 0; i < MAX_CHARS; i++) digit_q[i] <= digit_d[i];
    end
  end

  assign bus.core_message = msg_q;
  assign bus.core_length  = clen_q;
  assign bus.busy         = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign bus.done         = (state_q == ST_DONE);
  assign bus.found        = found_q;
  assign bus.result       = result_q;
  assign bus.result_len   = rlen_q;
  assign bus.tried        = tried_q;
  assign bus.state        = state_q;

endmodule
